// File: rtl/clk_gate_seq.sv
// Clock-gate sequencer: idle-timed quiesce/gating and staggered
// round-robin wake-up for NumDomains gated clock domains.
//
// Ports:
//   clk_i          always-on clock
//   rst_i          synchronous active-high reset
//   busy_i         per-domain work in flight
//   wake_req_i     per-domain level request, held until wake_ack_o
//   force_on_i     per-domain override keeping/bringing clock on
//   quiesce_ack_i  per-domain drained indication
//   quiesce_req_o  per-domain drain request (state DRAIN)
//   wake_ack_o     per-domain clock running and settled (state ON)
//   clk_en_o       per-domain gating-cell enable (state != OFF)
module clk_gate_seq #(
    parameter int unsigned NumDomains    = 4,
    parameter int unsigned IdleCycles    = 16,
    parameter int unsigned WakeCycles    = 2,
    parameter int unsigned StaggerCycles = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumDomains-1:0] busy_i,
    input  logic [NumDomains-1:0] wake_req_i,
    input  logic [NumDomains-1:0] force_on_i,
    input  logic [NumDomains-1:0] quiesce_ack_i,
    output logic [NumDomains-1:0] quiesce_req_o,
    output logic [NumDomains-1:0] wake_ack_o,
    output logic [NumDomains-1:0] clk_en_o
);

    localparam int unsigned IW =
        (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
    localparam int unsigned WW =
        (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
    localparam int unsigned SW =
        (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
    localparam int unsigned PW =
        (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [IW-1:0] IdleLast = IW'(IdleCycles - 1);
    localparam logic [WW-1:0] WakeLast = WW'(WakeCycles - 1);
    localparam logic [SW-1:0] StagLast = SW'(StaggerCycles - 1);
    localparam logic [PW-1:0] PtrLast  = PW'(NumDomains - 1);

    typedef enum logic [1:0] {
        ST_ON,
        ST_DRAIN,
        ST_OFF,
        ST_WAKE
    } state_e;

    state_e        state_q [NumDomains];
    logic [IW-1:0] idle_q  [NumDomains];
    logic [WW-1:0] wake_q  [NumDomains];
    logic [SW-1:0] stag_q;
    logic [PW-1:0] ptr_q;

    logic [NumDomains-1:0] want;
    logic [NumDomains-1:0] pend;
    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         nxt_ptr;
    logic                  grant;

    assign want = busy_i | wake_req_i | force_on_i;

    always_comb begin
        pend = '0;
        for (int k = 0; k < NumDomains; k++) begin
            pend[k] = want[k] && (state_q[k] == ST_OFF);
        end
    end

    // Round-robin pick: lowest pending index at or above the
    // pointer, otherwise wrap to the lowest pending index overall.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NumDomains - 1; k >= 0; k--) begin
            if (pend[k]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(k);
            end
        end
        for (int k = NumDomains - 1; k >= 0; k--) begin
            if (pend[k] && (PW'(k) >= ptr_q)) begin
                gnt_idx = PW'(k);
            end
        end
    end

    assign grant   = gnt_any && (stag_q == '0);
    assign nxt_ptr = (gnt_idx == PtrLast) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumDomains; k++) begin
                state_q[k] <= ST_ON;
                idle_q[k]  <= '0;
                wake_q[k]  <= '0;
            end
            stag_q <= '0;
            ptr_q  <= '0;
        end else begin
            if (grant) begin
                stag_q <= StagLast;
                ptr_q  <= nxt_ptr;
            end else if (stag_q != '0) begin
                stag_q <= stag_q - SW'(1);
            end

            for (int k = 0; k < NumDomains; k++) begin
                unique case (state_q[k])
                    ST_ON: begin
                        if (want[k]) begin
                            idle_q[k] <= '0;
                        end else if (idle_q[k] == IdleLast) begin
                            idle_q[k]  <= '0;
                            state_q[k] <= ST_DRAIN;
                        end else begin
                            idle_q[k] <= idle_q[k] + IW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        // New work aborts the drain even if the ack
                        // arrives in the same cycle.
                        if (want[k]) begin
                            idle_q[k]  <= '0;
                            state_q[k] <= ST_ON;
                        end else if (quiesce_ack_i[k]) begin
                            state_q[k] <= ST_OFF;
                        end
                    end
                    ST_OFF: begin
                        if (grant && (gnt_idx == PW'(k))) begin
                            wake_q[k]  <= WakeLast;
                            idle_q[k]  <= '0;
                            state_q[k] <= ST_WAKE;
                        end
                    end
                    ST_WAKE: begin
                        if (wake_q[k] == '0) begin
                            state_q[k] <= ST_ON;
                        end else begin
                            wake_q[k] <= wake_q[k] - WW'(1);
                        end
                    end
                    default: begin
                        state_q[k] <= ST_ON;
                    end
                endcase
            end
        end
    end

    always_comb begin
        clk_en_o      = '0;
        quiesce_req_o = '0;
        wake_ack_o    = '0;
        for (int k = 0; k < NumDomains; k++) begin
            clk_en_o[k]      = (state_q[k] != ST_OFF);
            quiesce_req_o[k] = (state_q[k] == ST_DRAIN);
            wake_ack_o[k]    = (state_q[k] == ST_ON);
        end
    end

endmodule

// File: tb/tb_clk_gate_seq.sv
// Testbench for clk_gate_seq: directed vector table, corner
// sequences, and randomized run against a behavioural model.
module tb_clk_gate_seq;

    localparam int N = 4;
    localparam int I = 16;
    localparam int W = 2;
    localparam int S = 4;

    localparam int M_ON    = 0;
    localparam int M_DRAIN = 1;
    localparam int M_OFF   = 2;
    localparam int M_WAKE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busy;
    logic [3:0] wreq;
    logic [3:0] frc;
    logic [3:0] qack;
    logic [3:0] qreq;
    logic [3:0] wack;
    logic [3:0] cen;

    always #5 clk = ~clk;

    clk_gate_seq #(
        .NumDomains   (N),
        .IdleCycles   (I),
        .WakeCycles   (W),
        .StaggerCycles(S)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .busy_i       (busy),
        .wake_req_i   (wreq),
        .force_on_i   (frc),
        .quiesce_ack_i(qack),
        .quiesce_req_o(qreq),
        .wake_ack_o   (wack),
        .clk_en_o     (cen)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic check(input string nm, input logic [3:0] act,
                         input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] busy;
        logic [3:0] wreq;
        logic [3:0] frc;
        logic [3:0] qa;
        int         n;
        logic [3:0] en;
        logic [3:0] ack;
        logic [3:0] qr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] b, logic [3:0] w,
                                logic [3:0] q, int n, logic [3:0] e,
                                logic [3:0] a, logic [3:0] qr);
        vec_t v;
        v.rst  = r;
        v.busy = b;
        v.wreq = w;
        v.frc  = 4'h0;
        v.qa   = q;
        v.n    = n;
        v.en   = e;
        v.ack  = a;
        v.qr   = qr;
        return v;
    endfunction

    // Behavioural model: per-domain mode, consecutive idle run,
    // remaining wake cycles, grant timestamp for stagger.
    int mode  [N];
    int run   [N];
    int wleft [N];
    int rr;
    int cyc;
    int last_g;

    task automatic model_step(input logic r, input logic [3:0] b,
                              input logic [3:0] w, input logic [3:0] f,
                              input logic [3:0] q);
        int gd;
        logic wt;
        if (r) begin
            for (int d = 0; d < N; d++) begin
                mode[d] = M_ON;
                run[d]  = 0;
                wleft[d] = 0;
            end
            rr     = 0;
            last_g = -1000;
        end else begin
            gd = -1;
            if (cyc - last_g >= S) begin
                for (int o = 0; o < N; o++) begin
                    int d;
                    d = (rr + o) % N;
                    if (gd < 0 && mode[d] == M_OFF &&
                        (b[d] | w[d] | f[d]))
                        gd = d;
                end
            end
            for (int d = 0; d < N; d++) begin
                wt = b[d] | w[d] | f[d];
                case (mode[d])
                    M_ON: begin
                        run[d] = wt ? 0 : run[d] + 1;
                        if (run[d] == I) begin
                            mode[d] = M_DRAIN;
                            run[d]  = 0;
                        end
                    end
                    M_DRAIN: begin
                        if (wt) begin
                            mode[d] = M_ON;
                            run[d]  = 0;
                        end else if (q[d]) begin
                            mode[d] = M_OFF;
                        end
                    end
                    M_OFF: begin
                        if (d == gd) begin
                            mode[d]  = M_WAKE;
                            wleft[d] = W;
                        end
                    end
                    default: begin
                        wleft[d]--;
                        if (wleft[d] == 0) mode[d] = M_ON;
                    end
                endcase
            end
            if (gd >= 0) begin
                rr     = (gd + 1) % N;
                last_g = cyc;
            end
        end
        cyc++;
    endtask

    function automatic logic [3:0] m_out(input int sel);
        logic [3:0] v;
        v = '0;
        for (int d = 0; d < N; d++) begin
            if (sel == 0) v[d] = (mode[d] != M_OFF);
            if (sel == 1) v[d] = (mode[d] == M_ON);
            if (sel == 2) v[d] = (mode[d] == M_DRAIN);
        end
        return v;
    endfunction

    initial begin
        rst  = 1'b1;
        busy = '0;
        wreq = '0;
        frc  = '0;
        qack = '0;
        cyc  = 0;

        tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 1,  4'hF, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 15, 4'hF, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1,  4'hF, 4'h0, 4'hF));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 1,  4'hE, 4'h0, 4'hE));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'hE, 1,  4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 1,  4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 3,  4'h1, 4'h1, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 1,  4'h3, 4'h1, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4,  4'h7, 4'h3, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4,  4'hF, 4'h7, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'h0, 2,  4'hF, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 16, 4'hF, 4'h0, 4'hF));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'hF, 1,  4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hA, 4'h0, 1,  4'h2, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hA, 4'h0, 4,  4'hA, 4'h2, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hA, 4'h0, 2,  4'hA, 4'hA, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hA, 4'h0, 2,  4'hA, 4'hA, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hE, 4'h0, 1,  4'hE, 4'hA, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hE, 4'h0, 1,  4'hE, 4'hA, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'hE, 4'h0, 1,  4'hE, 4'hE, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 16, 4'hE, 4'h0, 4'hE));
        tbl.push_back(mk(0, 4'h2, 4'h0, 4'h2, 1,  4'hE, 4'h2, 4'hC));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 15, 4'hE, 4'h2, 4'hC));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1,  4'hE, 4'h0, 4'hE));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'hE, 1,  4'h0, 4'h0, 4'h0));

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            busy = tbl[i].busy;
            wreq = tbl[i].wreq;
            frc  = tbl[i].frc;
            qack = tbl[i].qa;
            tick(tbl[i].n);
            check($sformatf("vec%0d_clk_en", i), cen, tbl[i].en);
            check($sformatf("vec%0d_wake_ack", i), wack, tbl[i].ack);
            check($sformatf("vec%0d_qreq", i), qreq, tbl[i].qr);
        end

        // Force override keeps domain 1 out of DRAIN.
        rst = 1'b1; busy = '0; wreq = '0; qack = '0; frc = '0;
        tick(1);
        rst = 1'b0;
        frc = 4'h2;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            check("force_qreq1", {3'b0, qreq[1]}, 4'h0);
            check("force_ack1", {3'b0, wack[1]}, 4'h1);
        end
        check("force_others_drain", qreq, 4'hD);
        frc = '0;

        // Reset while domain 3 is waking and domain 0 is draining.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(16);
        check("mid_all_drain", qreq, 4'hF);
        qack = 4'h8;
        tick(1);
        qack = 4'h0;
        wreq = 4'h8;
        tick(1);
        check("mid_pre_en", cen, 4'hF);
        check("mid_pre_ack", wack, 4'h0);
        check("mid_pre_qreq", qreq, 4'h7);
        rst = 1'b1;
        tick(1);
        check("mid_rst_en", cen, 4'hF);
        check("mid_rst_ack", wack, 4'hF);
        check("mid_rst_qreq", qreq, 4'h0);
        rst  = 1'b0;
        wreq = '0;

        // Randomized run against the model.
        rst = 1'b1;
        model_step(rst, busy, wreq, frc, qack);
        tick(1);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] ack_m;
            check("rnd_clk_en", cen, m_out(0));
            check("rnd_wake_ack", wack, m_out(1));
            check("rnd_qreq", qreq, m_out(2));
            ack_m = m_out(1);
            rst = ($urandom_range(0, 499) == 0);
            for (int d = 0; d < N; d++) begin
                busy[d] = ($urandom_range(0, 39) == 0);
                frc[d]  = ($urandom_range(0, 149) == 0);
                qack[d] = ($urandom_range(0, 3) == 0);
                if (wreq[d] && ack_m[d] && $urandom_range(0, 1) == 0)
                    wreq[d] = 1'b0;
                else if (!wreq[d] && $urandom_range(0, 59) == 0)
                    wreq[d] = 1'b1;
            end
            model_step(rst, busy, wreq, frc, qack);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule
